// File: rtl/data_async.sv
`default_nettype none
// ============================================================================
// Module   : data_async
// Brief    : Single-clock valid/ready transfer built as a toggle-handshake
//            crossing with SYNC_STAGES synchronizer flops in each direction,
//            plus an optional fixed-latency pulse channel enabled by the
//            macro DATA_ASYNC_PULSE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module data_async #(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic                  s_pulse,
    output logic                  m_pulse
);

    // ------------------------------------------------------------------
    // Source side: capture, req toggle, ack synchronizer
    // ------------------------------------------------------------------
    logic                   r_req;
    logic                   r_s_ready;
    logic [DATA_WIDTH-1:0]  r_hold;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_s_fire;

    // ------------------------------------------------------------------
    // Sink side: req synchronizer, local req copy, output register, ack
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_req_sync;
    logic                   r_req_seen;
    logic                   r_ack;
    logic                   r_m_valid;
    logic [DATA_WIDTH-1:0]  r_m_data;
    logic                   w_m_fire;

    assign w_s_fire = s_valid & r_s_ready;
    assign w_m_fire = r_m_valid & m_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_req      <= 1'b0;
            r_s_ready  <= 1'b0;
            r_hold     <= '0;
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], r_ack};
            if (w_s_fire) begin
                r_hold    <= s_data;
                r_req     <= ~r_req;
                r_s_ready <= 1'b0;
            end else if (r_ack_sync[SYNC_STAGES-1] == r_req) begin
                // Returned ack matches the outstanding req: channel is idle.
                r_s_ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_req_sync <= '0;
            r_req_seen <= 1'b0;
            r_ack      <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
        end else begin
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], r_req};
            if (w_m_fire) begin
                r_m_valid <= 1'b0;
                r_ack     <= ~r_ack;
            end else if (r_req_sync[SYNC_STAGES-1] != r_req_seen) begin
                // The hold register has been stable since the req toggle.
                r_m_data   <= r_hold;
                r_m_valid  <= 1'b1;
                r_req_seen <= r_req_sync[SYNC_STAGES-1];
            end
        end
    end

    assign s_ready = r_s_ready;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;

    // ------------------------------------------------------------------
    // Pulse channel: plain delay line of SYNC_STAGES+1 flops
    // ------------------------------------------------------------------
`ifdef DATA_ASYNC_PULSE_EN
    localparam int c_PULSE_DEPTH = SYNC_STAGES + 1;

    logic [c_PULSE_DEPTH-1:0] r_pulse_pipe;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_pulse_pipe <= '0;
        end else begin
            r_pulse_pipe <= {r_pulse_pipe[c_PULSE_DEPTH-2:0], s_pulse};
        end
    end

    assign m_pulse = r_pulse_pipe[c_PULSE_DEPTH-1];
`else
    logic w_unused_pulse;

    assign w_unused_pulse = s_pulse;
    assign m_pulse        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_async.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_async
// Brief    : Scoreboard bench for data_async: accepted source words are queued,
//            a monitor pops and compares on every sink handshake.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_data_async;

    localparam int c_DW  = 16;
    localparam int c_LAT = 3;

    logic            aclk;
    logic            aresetn;
    logic [c_DW-1:0] s_data;
    logic            s_valid;
    logic            s_ready;
    logic [c_DW-1:0] m_data;
    logic            m_valid;
    logic            m_ready;
    logic            s_pulse;
    logic            m_pulse;

    data_async #(
        .DATA_WIDTH  (c_DW),
        .SYNC_STAGES (2)
    ) u_dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .s_pulse (s_pulse),
        .m_pulse (m_pulse)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int              n_total = 0;
    int              n_pass  = 0;
    logic [c_DW-1:0] exp_q[$];
    int              n_deliv = 0;
    logic [c_DW-1:0] last_deliv = '0;
    logic [c_DW-1:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Expected word is queued when the source handshake is about to happen.
    always @(negedge aclk) begin
        if (aresetn && s_valid && s_ready) exp_q.push_back(s_data);
    end

    always @(negedge aclk) begin
        if (aresetn && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL deliver: got %0h, expected no word (queue empty)", m_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("deliver", {16'h0, m_data}, {16'h0, mon_exp});
            end
            n_deliv++;
            last_deliv = m_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1);
    end

    int   bad;
    int   cyc;
    int   d0;
    int   cnt;
    logic acc;
    logic hist [64];
    logic pexp;

    initial begin
        aresetn = 1'b1;
        s_data  = '0;
        s_valid = 1'b1;
        m_ready = 1'b0;
        s_pulse = 1'b1;
        #1 aresetn = 1'b0;

        // Reset: outputs low for 100 cycles while s_valid and s_pulse are high
        bad = 0;
        repeat (100) begin
            @(negedge aclk);
            if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || m_pulse !== 1'b0) bad++;
        end
        check("reset_outputs", bad, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        s_pulse = 1'b0;
        s_valid = 1'b0;
        check("s_ready_before_edge", {31'h0, s_ready}, 1'b0);
        tick();
        check("s_ready_first_edge", {31'h0, s_ready}, 1'b1);
        check("m_valid_after_reset", {31'h0, m_valid}, 1'b0);

        // Single word with sink always ready
        s_data  = 16'h1234;
        s_valid = 1'b1;
        m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        check("s_ready_drop", {31'h0, s_ready}, 1'b0);
        cyc = 0;
        while (!m_valid && cyc < 20) begin tick(); cyc++; end
        check("fwd_latency", cyc, c_LAT);
        check("single_data", {16'h0, m_data}, 32'h1234);
        tick();
        check("m_valid_clear", {31'h0, m_valid}, 1'b0);
        check("m_data_hold", {16'h0, m_data}, 32'h1234);
        cyc = 0;
        while (!s_ready && cyc < 20) begin tick(); cyc++; end
        check("ret_latency", cyc, c_LAT);

        // Sink stall: word held 20 cycles, source tries to push meanwhile
        m_ready = 1'b0;
        s_data  = 16'h00AA;
        s_valid = 1'b1;
        tick();
        s_data  = 16'hFFFF;
        cyc = 0;
        while (!m_valid && cyc < 20) begin tick(); cyc++; end
        check("stall_fwd_latency", cyc, c_LAT);
        bad = 0;
        repeat (20) begin
            tick();
            if (m_valid !== 1'b1 || m_data !== 16'h00AA || s_ready !== 1'b0) bad++;
        end
        check("stall_hold", bad, 0);
        s_valid = 1'b0;
        d0 = n_deliv;
        m_ready = 1'b1;
        repeat (10) tick();
        check("stall_single_transfer", n_deliv - d0, 1);
        check("stall_s_ready_back", {31'h0, s_ready}, 1'b1);
        check("stall_m_data_kept", {16'h0, m_data}, 32'h00AA);

        // Reset between source handshake and m_valid
        s_data  = 16'h0BAD;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        aresetn = 1'b0;
        exp_q.delete();
        bad = 0;
        repeat (5) begin
            @(negedge aclk);
            if (m_valid !== 1'b0 || s_ready !== 1'b0) bad++;
        end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (8) begin
            tick();
            if (m_valid !== 1'b0) bad++;
        end
        check("midflight_discard", bad, 0);
        d0 = n_deliv;
        s_data  = 16'h0005;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        cyc = 0;
        while (!m_valid && cyc < 20) begin tick(); cyc++; end
        check("post_reset_latency", cyc, c_LAT);
        tick();
        check("first_after_reset", {16'h0, last_deliv}, 32'h0005);
        check("post_reset_count", n_deliv - d0, 1);
        repeat (5) tick();

        // Random stream of an incrementing counter
        cnt    = 0;
        s_data = '0;
        d0     = n_deliv;
        for (int i = 0; i < 10000; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            @(negedge aclk);
            acc = s_valid && s_ready;
            @(posedge aclk); #1;
            if (acc) begin
                cnt++;
                s_data = c_DW'(cnt);
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (20) tick();
        check("stream_drained", exp_q.size(), 0);
        check("stream_count", n_deliv - d0, cnt);
        check("stream_progress", {31'h0, cnt > 500}, 1'b1);

        // Pulse channel: constant 1, then 1010 pattern, then 0
        m_ready = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(posedge aclk); #1;
`ifdef DATA_ASYNC_PULSE_EN
            pexp = (t >= c_LAT) ? hist[t-c_LAT] : 1'b0;
`else
            pexp = 1'b0;
`endif
            check("pulse", {31'h0, m_pulse}, {31'h0, pexp});
            if (t < 10)      s_pulse = 1'b1;
            else if (t < 26) s_pulse = (t % 2 == 0);
            else             s_pulse = 1'b0;
            hist[t] = s_pulse;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
